// File: rtl/operand_fetch.sv
// Operand fetch stage: reads two sources from the register bank with write-back forwarding,
// and keeps a per-register pending scoreboard. Define OPERAND_FETCH_ZERO_REG_EN for a hardwired r0.
module operand_fetch #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned SIZE       = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [WORD_WIDTH-1:0] i_regs [SIZE],
  input  logic                  i_wb_write,
  input  logic [ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [WORD_WIDTH-1:0] i_wb_value,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_rs1,
  input  logic [ADDR_WIDTH-1:0] i_req_rs2,
  input  logic [ADDR_WIDTH-1:0] i_req_rd,
  input  logic                  i_req_lock,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [WORD_WIDTH-1:0] o_rsp_op1,
  output logic [WORD_WIDTH-1:0] o_rsp_op2,
  input  logic                  i_flush,
  output logic [SIZE-1:0]       o_busy
);

`ifdef OPERAND_FETCH_ZERO_REG_EN
  localparam bit ZeroRegEn = 1'b1;
`else
  localparam bit ZeroRegEn = 1'b0;
`endif

  logic [SIZE-1:0]       busy_q, busy_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [WORD_WIDTH-1:0] op1_q, op1_d;
  logic [WORD_WIDTH-1:0] op2_q, op2_d;

  logic [WORD_WIDTH-1:0] rs1_val, rs2_val;
  logic                  hz_rs1, hz_rs2, hz_rd;
  logic                  lock_eff;
  logic                  slot_free;
  logic                  accept;

  // Source reads: the write being committed this cycle overrides the bank's stale value.
  always_comb begin
    rs1_val = i_regs[i_req_rs1];
    if (i_wb_write && (i_wb_addr == i_req_rs1)) begin
      rs1_val = i_wb_value;
    end
    if (ZeroRegEn && (i_req_rs1 == '0)) begin
      rs1_val = '0;
    end
  end

  always_comb begin
    rs2_val = i_regs[i_req_rs2];
    if (i_wb_write && (i_wb_addr == i_req_rs2)) begin
      rs2_val = i_wb_value;
    end
    if (ZeroRegEn && (i_req_rs2 == '0)) begin
      rs2_val = '0;
    end
  end

  // A pending mark cleared by this cycle's write-back no longer blocks.
  always_comb begin
    lock_eff = i_req_lock && !(ZeroRegEn && (i_req_rd == '0));
    hz_rs1   = busy_q[i_req_rs1] && !(i_wb_write && (i_wb_addr == i_req_rs1));
    hz_rs2   = busy_q[i_req_rs2] && !(i_wb_write && (i_wb_addr == i_req_rs2));
    hz_rd    = lock_eff && busy_q[i_req_rd] && !(i_wb_write && (i_wb_addr == i_req_rd));
  end

  always_comb begin
    slot_free   = !rsp_valid_q || i_rsp_ready;
    o_req_ready = slot_free && !(hz_rs1 || hz_rs2 || hz_rd) && !i_flush;
    accept      = i_req_valid && o_req_ready;
  end

  // Scoreboard: write-back clears, acceptance sets (set wins), flush clears everything.
  always_comb begin
    busy_d = busy_q;
    if (i_wb_write) begin
      busy_d[i_wb_addr] = 1'b0;
    end
    if (accept && lock_eff) begin
      busy_d[i_req_rd] = 1'b1;
    end
    if (i_flush) begin
      busy_d = '0;
    end
    if (ZeroRegEn) begin
      busy_d[0] = 1'b0;
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    if (i_flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept) begin
      rsp_valid_d = 1'b1;
      op1_d       = rs1_val;
      op2_d       = rs2_val;
    end else if (rsp_valid_q && i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q      <= '0;
      rsp_valid_q <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
    end else begin
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
    end
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_op1   = op1_q;
  assign o_rsp_op2   = op2_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: reads, forwarding, scoreboard stalls, backpressure,
// flush and asynchronous reset, plus register 0 behaviour for either build.
module tb_operand_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] regs [16];
  logic        wb_write;
  logic [3:0]  wb_addr;
  logic [31:0] wb_value;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_rs1, req_rs2, req_rd;
  logic        req_lock;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_op1, rsp_op2;
  logic        flush;
  logic [15:0] busy;

  int tests;
  int fails;

  operand_fetch #(
    .ADDR_WIDTH(4),
    .WORD_WIDTH(32),
    .SIZE      (16)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_regs     (regs),
    .i_wb_write (wb_write),
    .i_wb_addr  (wb_addr),
    .i_wb_value (wb_value),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_rs1  (req_rs1),
    .i_req_rs2  (req_rs2),
    .i_req_rd   (req_rd),
    .i_req_lock (req_lock),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_op1  (rsp_op1),
    .o_rsp_op2  (rsp_op2),
    .i_flush    (flush),
    .o_busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_lock  = 1'b0;
    wb_write  = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic req(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                     input logic lock);
    req_valid = 1'b1;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
    req_lock  = lock;
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] v);
    wb_write = 1'b1;
    wb_addr  = a;
    wb_value = v;
  endtask

  task automatic test_reset();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_op1 !== 32'h0) begin fails++; $display("FAIL reset_op1: got %h want 0", rsp_op1); end
    tests++; if (rsp_op2 !== 32'h0) begin fails++; $display("FAIL reset_op2: got %h want 0", rsp_op2); end
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL reset_busy: got %h want 0", busy); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_basic_read();
    regs[3] = 32'h11;
    regs[5] = 32'h22;
    req(4'd3, 4'd5, 4'd1, 1'b0);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL basic_ready: got %b want 1", req_ready); end
    step();
    idle();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
    tests++; if (rsp_op1 !== 32'h11) begin fails++; $display("FAIL basic_op1: got %h want 11", rsp_op1); end
    tests++; if (rsp_op2 !== 32'h22) begin fails++; $display("FAIL basic_op2: got %h want 22", rsp_op2); end
    step();
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_taken: got %b want 0", rsp_valid); end
  endtask

  task automatic test_forwarding();
    req(4'd3, 4'd5, 4'd1, 1'b0);
    wb(4'd3, 32'hAA);
    step();
    idle();
    tests++; if (rsp_op1 !== 32'hAA) begin fails++; $display("FAIL fwd_op1: got %h want aa", rsp_op1); end
    tests++; if (rsp_op2 !== 32'h22) begin fails++; $display("FAIL fwd_op2: got %h want 22", rsp_op2); end
    step();
  endtask

  task automatic test_scoreboard();
    req(4'd1, 4'd2, 4'd7, 1'b1);
    step();
    tests++; if (busy !== 16'h0080) begin fails++; $display("FAIL sb_set: got %h want 0080", busy); end
    req(4'd7, 4'd2, 4'd1, 1'b0);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sb_stall0: got %b want 0", req_ready); end
    step();
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sb_stall1: got %b want 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL sb_drain: got %b want 0", rsp_valid); end
    wb(4'd7, 32'h55);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL sb_release: got %b want 1", req_ready); end
    step();
    idle();
    tests++; if (rsp_op1 !== 32'h55) begin fails++; $display("FAIL sb_op1: got %h want 55", rsp_op1); end
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL sb_clear: got %h want 0", busy); end
    // Same-cycle set and clear of r6: the set wins.
    req(4'd1, 4'd2, 4'd6, 1'b1);
    wb(4'd6, 32'h66);
    step();
    idle();
    tests++; if (busy !== 16'h0040) begin fails++; $display("FAIL sb_setwins: got %h want 0040", busy); end
    req(4'd1, 4'd2, 4'd6, 1'b1);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL sb_waw: got %b want 0", req_ready); end
    wb(4'd6, 32'h67);
    step();
    idle();
    tests++; if (busy !== 16'h0040) begin fails++; $display("FAIL sb_waw_relock: got %h want 0040", busy); end
    wb(4'd6, 32'h68);
    step();
    idle();
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL sb_wb_clear: got %h want 0", busy); end
    wb(4'd9, 32'h69);
    step();
    idle();
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL sb_wb_idle: got %h want 0", busy); end
  endtask

  task automatic test_backpressure();
    regs[3] = 32'h11;
    regs[5] = 32'h22;
    rsp_ready = 1'b0;
    req(4'd3, 4'd5, 4'd1, 1'b0);
    step();
    req(4'd5, 4'd3, 4'd1, 1'b0);
    regs[5] = 32'h99;
    for (int i = 0; i < 3; i++) begin
      tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready%0d: got %b want 0", i, req_ready); end
      step();
      tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_valid%0d: got %b want 1", i, rsp_valid); end
      tests++; if (rsp_op1 !== 32'h11 || rsp_op2 !== 32'h22) begin
        fails++; $display("FAIL bp_hold%0d: got %h/%h want 11/22", i, rsp_op1, rsp_op2);
      end
    end
    rsp_ready = 1'b1;
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got %b want 1", req_ready); end
    step();
    idle();
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_next_valid: got %b want 1", rsp_valid); end
    tests++; if (rsp_op1 !== 32'h99 || rsp_op2 !== 32'h11) begin
      fails++; $display("FAIL bp_next_ops: got %h/%h want 99/11", rsp_op1, rsp_op2);
    end
    step();
    regs[5] = 32'h22;
  endtask

  task automatic load_held();
    req(4'd1, 4'd2, 4'd4, 1'b1);
    step();
    req(4'd1, 4'd2, 4'd9, 1'b1);
    step();
    idle();
    rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_flush();
    load_held();
    tests++; if (busy !== 16'h0210) begin fails++; $display("FAIL fl_busy_pre: got %h want 0210", busy); end
    tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL fl_held: got %b want 1", rsp_valid); end
    rsp_ready = 1'b1;
    flush = 1'b1;
    req(4'd1, 4'd2, 4'd3, 1'b1);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL fl_ready: got %b want 0", req_ready); end
    step();
    idle();
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL fl_busy: got %h want 0", busy); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL fl_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_async_reset();
    load_held();
    tests++; if (rsp_op1 !== 32'h1001) begin fails++; $display("FAIL ar_pre_op1: got %h want 1001", rsp_op1); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL ar_valid: got %b want 0", rsp_valid); end
    tests++; if (rsp_op1 !== 32'h0 || rsp_op2 !== 32'h0) begin
      fails++; $display("FAIL ar_ops: got %h/%h want 0/0", rsp_op1, rsp_op2);
    end
    tests++; if (busy !== 16'h0) begin fails++; $display("FAIL ar_busy: got %h want 0", busy); end
    #1 rst_n = 1'b1;
    idle();
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL ar_ready: got %b want 1", req_ready); end
    step();
  endtask

  task automatic test_zero_reg();
    regs[0] = 32'hFF;
    req(4'd0, 4'd3, 4'd0, 1'b1);
    step();
    idle();
`ifdef OPERAND_FETCH_ZERO_REG_EN
    tests++; if (rsp_op1 !== 32'h0) begin fails++; $display("FAIL zr_op1: got %h want 0", rsp_op1); end
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL zr_busy: got %b want 0", busy[0]); end
    req(4'd0, 4'd3, 4'd0, 1'b1);
    #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL zr_nohz: got %b want 1", req_ready); end
    step();
    idle();
`else
    tests++; if (rsp_op1 !== 32'hFF) begin fails++; $display("FAIL r0_op1: got %h want ff", rsp_op1); end
    tests++; if (busy[0] !== 1'b1) begin fails++; $display("FAIL r0_busy: got %b want 1", busy[0]); end
    wb(4'd0, 32'h5);
    step();
    idle();
    tests++; if (busy[0] !== 1'b0) begin fails++; $display("FAIL r0_clear: got %b want 0", busy[0]); end
`endif
    step();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000 + i;
    wb_addr  = '0;
    wb_value = '0;
    req_rs1  = '0;
    req_rs2  = '0;
    req_rd   = '0;
    idle();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    #1;
    test_reset();
    @(negedge clk);
    step();
    test_basic_read();
    test_forwarding();
    test_scoreboard();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_zero_reg();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
